// File: rtl/rb_loader.sv
// Configuration loader: streams weight/bias/sign bytes into each neuron register bank in index order.
// Each accepted byte becomes one registered write strobe on the following cycle.
module rb_loader #(
    parameter int N_NEURONS = 4,
    parameter int IW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic [7:0]           rb_data,
    output logic [1:0]           rb_select,
    output logic [N_NEURONS-1:0] rb_en,
    output logic                 rb_trig,
    output logic                 busy,
    output logic                 done,
    output logic [IW-1:0]        idx
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_W = 2'd1;
    localparam logic [1:0] LOAD_B = 2'd2;
    localparam logic [1:0] LOAD_S = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 trig_q, trig_d;
    logic                 done_q, done_d;
    logic [7:0]           data_q, data_d;
    logic [1:0]           sel_q, sel_d;
    logic [N_NEURONS-1:0] en_q, en_d;
    logic                 accept;

    assign busy    = (state_q != IDLE);
    assign s_ready = busy && !abort;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        trig_d  = accept;
        data_d  = data_q;
        sel_d   = sel_q;
        en_d    = '0;
        if (accept) begin
            data_d = s_data;
            en_d   = N_NEURONS'(1) << idx_q;
        end
        // Abort only matters mid-load; in IDLE a simultaneous start still begins a load.
        if (busy && abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD_W;
                        idx_d   = '0;
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        sel_d   = 2'd0;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        sel_d   = 2'd1;
                        state_d = LOAD_S;
                    end
                end
                LOAD_S: begin
                    if (accept) begin
                        sel_d = 2'd2;
                        if (idx_q == IW'(N_NEURONS - 1)) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LOAD_W;
                            idx_d   = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'd0;
            sel_q   <= 2'd0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    assign rb_trig   = trig_q;
    assign rb_en     = en_q;
    assign rb_data   = data_q;
    assign rb_select = sel_q;
    assign done      = done_q;
    assign idx       = idx_q;

endmodule

// File: tb/tb_rb_loader.sv
// Self-checking bench for rb_loader: directed load scenarios plus random traffic against
// a byte-position model of a full load (3 bytes per neuron, in neuron order).
module tb_rb_loader;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic [7:0]    rb_data;
    logic [1:0]    rb_select;
    logic [N-1:0]  rb_en;
    logic          rb_trig;
    logic          busy;
    logic          done;
    logic [IW-1:0] idx;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model: whether a load is running and how many bytes of it were taken.
    bit          loading;
    int          pos;
    bit          expTrig;
    bit          expDone;
    logic [7:0]  expData;
    logic [1:0]  expSel;
    logic [N-1:0] expEn;

    rb_loader #(.N_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rb_data(rb_data), .rb_select(rb_select), .rb_en(rb_en),
        .rb_trig(rb_trig), .busy(busy), .done(done), .idx(idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        loading = 0;
        pos     = 0;
        expTrig = 0;
        expDone = 0;
        expData = 8'h00;
        expSel  = 2'd0;
        expEn   = '0;
    endtask

    task automatic modelStep();
        bit acc;
        acc     = loading && !abort && s_valid;
        expTrig = acc;
        expDone = 0;
        expEn   = '0;
        if (acc) begin
            expData = s_data;
            expSel  = 2'(pos % 3);
            expEn   = N'(1) << (pos / 3);
        end
        if (!loading) begin
            if (start) begin
                loading = 1;
                pos     = 0;
            end
        end else if (abort) begin
            loading = 0;
            pos     = 0;
        end else if (acc) begin
            if (pos == 3 * N - 1) begin
                loading = 0;
                pos     = 0;
                expDone = 1;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic checkRegistered();
        checkOutput("rb_trig",   32'(rb_trig),   32'(expTrig));
        checkOutput("rb_en",     32'(rb_en),     32'(expEn));
        checkOutput("rb_select", 32'(rb_select), 32'(expSel));
        checkOutput("rb_data",   32'(rb_data),   32'(expData));
        checkOutput("done",      32'(done),      32'(expDone));
        checkOutput("busy",      32'(busy),      32'(loading));
        checkOutput("idx",       32'(idx),       32'(pos / 3));
    endtask

    // One clock cycle: drive on the falling edge, check s_ready, then check registered outputs after the rising edge.
    task automatic applyStimulus(input bit st, input bit ab, input bit v, input logic [7:0] d);
        @(negedge clk);
        start   = st;
        abort   = ab;
        s_valid = v;
        s_data  = d;
        #1;
        checkOutput("s_ready", 32'(s_ready), 32'(loading && !ab));
        modelStep();
        @(posedge clk);
        #1;
        checkRegistered();
    endtask

    task automatic runLoad(input int gapAfter, input int startAt, input int abortAfter);
        applyStimulus(1, 0, 0, 8'h00);
        for (int b = 0; b < 3 * N; b++) begin
            if (b == gapAfter) begin
                repeat (3) applyStimulus(0, 0, 0, 8'hEE);
            end
            if (b == abortAfter) begin
                applyStimulus(0, 1, 1, 8'(16 + b));
                return;
            end
            applyStimulus(b == startAt, 0, 1, 8'(16 + b));
        end
        applyStimulus(0, 0, 0, 8'h00);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset s_ready", 32'(s_ready), 32'd0);
        checkRegistered();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] back-to-back load");
        runLoad(-1, -1, -1);

        $display("[TB] load with 3-cycle gap after byte 4");
        runLoad(4, -1, -1);

        $display("[TB] start pulsed mid-load");
        runLoad(-1, 5, -1);

        $display("[TB] abort after 7 accepts, then reload");
        runLoad(-1, -1, 7);
        applyStimulus(0, 0, 0, 8'h00);
        runLoad(-1, -1, -1);

        $display("[TB] reset during an active strobe");
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'hA5);
        applyStimulus(0, 0, 1, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async rb_trig", 32'(rb_trig), 32'd0);
        checkOutput("async rb_en",   32'(rb_en),   32'd0);
        checkOutput("async busy",    32'(busy),    32'd0);
        checkOutput("async s_ready", 32'(s_ready), 32'd0);
        checkOutput("async idx",     32'(idx),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 8'h77);

        $display("[TB] start and abort together in IDLE");
        applyStimulus(1, 1, 0, 8'h00);
        for (int b = 0; b < 3 * N; b++) applyStimulus(0, 0, 1, 8'(8'hC0 + b));
        applyStimulus(0, 0, 0, 8'h00);

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 7) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0,
                          8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rb_loader.md
Name: rb_loader

Overview:
- Sequencer that streams configuration bytes into the grid's per-neuron register banks (weight, bias, sign).
- Sits between the serial configuration interface and the N register banks of the serial neuron grid.
- Accepts a valid/ready byte stream and issues, per byte, one write strobe with bank select, register select and data.
- Per neuron, byte order is fixed: weight, bias, sign; neurons are loaded in index order 0..N_NEURONS-1.

Parameters:
- N_NEURONS, 4, number of register banks driven (>=2).
- IW, $clog2(N_NEURONS), width of the neuron index counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a full load; honoured only in IDLE.
- abort  in  1  synchronous abort of the load in progress.
- s_valid  in  1  byte available on s_data.
- s_data  in  8  configuration byte.
- s_ready  out  1  loader can accept a byte this cycle.
- rb_data  out  8  data bus to all banks.
- rb_select  out  2  register select: 0 = weight, 1 = bias, 2 = sign; 3 is never driven.
- rb_en  out  N_NEURONS  one-hot bank enable; all zero when rb_trig=0.
- rb_trig  out  1  write strobe; banks latch on the edge that ends the strobe cycle.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse: full load completed.
- idx  out  IW  current neuron index (debug/status).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - s_ready, busy, done, rb_trig = 0.
  - rb_en = 0, rb_data = 0, rb_select = 0, idx = 0.
- States: IDLE, LOAD_W, LOAD_B, LOAD_S.
- busy = 1 in LOAD_*. s_ready = busy && !abort (combinational).
- Handshake: a byte is accepted on any edge where s_valid && s_ready. s_data must hold while s_valid=1 && s_ready=0.
- IDLE:
  - start=1 -> LOAD_W, idx=0.
  - start and abort in the same cycle: start wins; abort is ignored because nothing is in progress.
- LOAD_W: on accept -> LOAD_B.
- LOAD_B: on accept -> LOAD_S.
- LOAD_S: on accept,
  - if idx < N_NEURONS-1: idx+1, -> LOAD_W;
  - else: -> IDLE, idx=0, done=1 for the next cycle.
- No accept: state holds. No timeout.
- Write issue, 1-cycle latency. For a byte accepted at edge k, during the cycle after k:
  - rb_trig=1;
  - rb_data = byte;
  - rb_select = 0, 1 or 2 per the accepting state;
  - rb_en = 1<<idx, using idx at accept time.
- A bank latches the byte at edge k+1. rb_trig is low in any cycle without a prior accept.
- rb_data and rb_select hold their last value when rb_trig=0.
- Throughput: one byte per cycle; back-to-back accepts give a continuous rb_trig with a changing select/en.
- Full load: exactly 3*N_NEURONS accepts.
- The final strobe and the done pulse occur in the same cycle. busy falls in that cycle.
- start while busy: ignored, no restart.
- abort while busy:
  - takes priority over accept (s_ready=0, no byte taken);
  - next state IDLE, idx=0, no done pulse;
  - a strobe already registered from the previous cycle still completes;
  - banks keep partially loaded values.
- Reset mid-load: all outputs return to reset values immediately; a pending strobe is dropped.

Test Plan:
- Reset, then start with N_NEURONS=4 and 12 back-to-back bytes 0x10..0x1B:
  - 12 consecutive rb_trig cycles;
  - bank 0 gets sel0=0x10, sel1=0x11, sel2=0x12; ...; bank 3 gets 0x19/0x1A/0x1B;
  - done=1 exactly once, in the same cycle as the 0x1B strobe;
  - busy=0 afterwards.
- Same load with s_valid deasserted for 3 cycles after byte 4:
  - no rb_trig during the gap;
  - rb_en=0b0010 with rb_select=1 for byte 5 (0x14);
  - remaining sequence unchanged.
- start pulsed at byte 6 of a load: no effect; load completes after exactly 12 accepts total.
- abort asserted with s_valid=1 after 7 accepts:
  - s_ready=0 that cycle, and the 8th byte is not accepted;
  - the strobe for byte 7 completes (rb_en=0b0100, rb_select=0);
  - state returns to IDLE, idx=0, no done pulse;
  - a subsequent start reloads from bank 0.
- rst_n pulled low while rb_trig=1:
  - rb_trig, rb_en, busy and s_ready go to 0 asynchronously;
  - after release, state is IDLE and idx=0.
- start and abort asserted together in IDLE: load begins (busy=1 next cycle, rb_select=0 on the first strobe).
